// File: rtl/prng_lfsr_gen.sv
// Galois-LFSR random word generator with start/stop FSM, zero-seed check and FWFT output FIFO.
// Define PRNG_HEALTH_EN to add the repeated-word health test that halts generation on failure.
module prng_lfsr_gen #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned OUT_W      = 64,
  parameter int unsigned STEPS      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REPEAT_LIM = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic             cfg_sel_i,
  input  logic [WIDTH-1:0] cfg_wdata_i,
  input  logic             lock_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             seed_err_o,
  output logic [OUT_W-1:0] rand_o,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic [31:0]      count_o,
  output logic             health_fail_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GEN  = 2'd2
  } state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] seed_q, poly_q, lfsr_q, lfsr_nxt_c;
  logic [CNT_W-1:0] step_q;
  logic [31:0]      count_q;
  logic             seed_err_q;

  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   fill_q;

  logic             empty_c, full_c, pop_c, push_c, step_c, load_c;
  logic             start_try_c, start_ok_c, health_blk_c, health_trip_c;
  logic [OUT_W-1:0] word_c;

  assign lfsr_nxt_c = lfsr_q[0] ? ((lfsr_q >> 1) ^ poly_q) : (lfsr_q >> 1);
  assign word_c     = lfsr_nxt_c[OUT_W-1:0];

  assign empty_c = (fill_q == '0);
  assign full_c  = (fill_q == FULL_LVL);
  assign pop_c   = !empty_c && rand_ready_i;

  // stop_i dominates start_i; a failed health test blocks any restart
  assign start_try_c = (fsm_q == S_IDLE) && start_i && !stop_i && !health_blk_c;
  assign start_ok_c  = start_try_c && (seed_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:  if (start_ok_c) fsm_d = S_LOAD;
      S_LOAD:  fsm_d = stop_i ? S_IDLE : S_GEN;
      S_GEN:   if (stop_i) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
    if (health_trip_c) fsm_d = S_IDLE;
  end

  // The word-producing step also fires in a stop cycle so an in-flight push completes
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    push_c = 1'b0;
    unique case (fsm_q)
      S_LOAD: load_c = !stop_i;
      S_GEN: begin
        if (step_q != LAST_STEP) step_c = 1'b1;
        else                     push_c = !full_c || pop_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seed_q     <= '0;
      poly_q     <= '0;
      lfsr_q     <= '0;
      step_q     <= '0;
      count_q    <= '0;
      seed_err_q <= 1'b0;
    end else begin
      if (cfg_we_i && !lock_i && !cfg_sel_i)                     seed_q <= cfg_wdata_i;
      if (cfg_we_i && !lock_i && cfg_sel_i && fsm_q == S_IDLE)   poly_q <= cfg_wdata_i;
      if (start_try_c) seed_err_q <= (seed_q == '0);
      if (load_c) begin
        lfsr_q <= seed_q;
        step_q <= '0;
      end else if (step_c) begin
        lfsr_q <= lfsr_nxt_c;
        step_q <= step_q + CNT_W'(1);
      end else if (push_c) begin
        lfsr_q <= lfsr_nxt_c;
        step_q <= '0;
      end
      if (push_c) count_q <= count_q + 32'd1;
    end
  end

  // First-word-fall-through FIFO; a health trip discards its contents
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (health_trip_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= word_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_c, pop_c})
        2'b10:   fill_q <= fill_q + (PTR_W + 1)'(1);
        2'b01:   fill_q <= fill_q - (PTR_W + 1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

`ifdef PRNG_HEALTH_EN
  localparam int unsigned REP_W = $clog2(REPEAT_LIM + 1);

  logic [OUT_W-1:0] last_q;
  logic [REP_W-1:0] rep_q, rep_nxt_c;
  logic             health_fail_q;

  // rep_q is the length of the current run of identical pushed words (0 = nothing pushed yet)
  always_comb begin
    rep_nxt_c = REP_W'(1);
    if (rep_q != '0 && word_c == last_q) rep_nxt_c = rep_q + REP_W'(1);
  end

  assign health_trip_c = push_c && (rep_nxt_c >= REP_W'(REPEAT_LIM));
  assign health_blk_c  = health_fail_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q        <= '0;
      rep_q         <= '0;
      health_fail_q <= 1'b0;
    end else if (push_c) begin
      last_q <= word_c;
      rep_q  <= rep_nxt_c;
      if (health_trip_c) health_fail_q <= 1'b1;
    end
  end

  assign health_fail_o = health_fail_q;
`else
  assign health_trip_c = 1'b0;
  assign health_blk_c  = 1'b0;
  assign health_fail_o = 1'b0;
`endif

  assign busy_o       = (fsm_q != S_IDLE);
  assign seed_err_o   = seed_err_q;
  assign rand_valid_o = !empty_c;
  assign rand_o       = empty_c ? '0 : mem_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Scoreboard bench for prng_lfsr_gen (8-bit LFSR, one step per word, 4-deep FIFO).
module tb_prng_lfsr_gen;

  logic        clk_i = 1'b0;
  logic        rst_i, cfg_we_i, cfg_sel_i, lock_i, start_i, stop_i, rand_ready_i;
  logic [7:0]  cfg_wdata_i;
  logic        busy_o, seed_err_o, rand_valid_o, health_fail_o;
  logic [7:0]  rand_o;
  logic [31:0] count_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  always #5 clk_i = ~clk_i;

  prng_lfsr_gen #(
    .WIDTH(8), .OUT_W(8), .STEPS(1), .FIFO_DEPTH(4), .REPEAT_LIM(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i),
    .cfg_wdata_i(cfg_wdata_i), .lock_i(lock_i), .start_i(start_i), .stop_i(stop_i),
    .busy_o(busy_o), .seed_err_o(seed_err_o), .rand_o(rand_o), .rand_valid_o(rand_valid_o),
    .rand_ready_i(rand_ready_i), .count_o(count_o), .health_fail_o(health_fail_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the expected queue
  always @(negedge clk_i) begin : mon
    logic [7:0] e;
    if (!rst_i && rand_valid_o && rand_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_unexpected: got 0x%0h expected no word", rand_o);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard_word", 32'(rand_o), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] data);
    cfg_sel_i   = sel;
    cfg_wdata_i = data;
    cfg_we_i    = 1'b1;
    tick();
    cfg_we_i    = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic setup(input logic [7:0] poly, input logic [7:0] seed);
    rand_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cfg_write(1'b1, poly);
    cfg_write(1'b0, seed);
  endtask

  task automatic push_exp5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] f);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    exp_q.push_back(d); exp_q.push_back(f);
  endtask

  // Start with ready=1 and stop so that exactly n words are produced
  task automatic run_words(input int n);
    rand_ready_i = 1'b1;
    pulse_start();
    repeat (n) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_sel_i = 1'b0; cfg_wdata_i = 8'h00;
    lock_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; rand_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(rand_valid_o), 32'd0);
    chk("rst_rand", 32'(rand_o), 32'd0);
    chk("rst_seed_err", 32'(seed_err_o), 32'd0);
    chk("rst_count", count_o, 32'd0);
    chk("rst_health", 32'(health_fail_o), 32'd0);

    // 1) basic sequence and first-word latency
    setup(8'hB8, 8'h01);
    push_exp5(8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3);
    rand_ready_i = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_valid_c1", 32'(rand_valid_o), 32'd0);
    tick();
    chk("t1_valid_c2", 32'(rand_valid_o), 32'd0);
    tick();
    chk("t1_valid_c3", 32'(rand_valid_o), 32'd1);
    repeat (3) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    repeat (3) tick();
    chk("t1_count", count_o, 32'd5);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2) zero seed is refused, then a good seed starts
    setup(8'hB8, 8'h00);
    pulse_start();
    chk("t2_seed_err", 32'(seed_err_o), 32'd1);
    chk("t2_busy_idle", 32'(busy_o), 32'd0);
    repeat (3) tick();
    chk("t2_no_valid", 32'(rand_valid_o), 32'd0);
    cfg_write(1'b0, 8'h01);
    pulse_start();
    chk("t2_seed_err_clr", 32'(seed_err_o), 32'd0);
    chk("t2_busy", 32'(busy_o), 32'd1);

    // 3) backpressure fills FIFO, config writes while busy, then drain
    setup(8'hB8, 8'h01);
    push_exp5(8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3);
    pulse_start();
    repeat (6) tick();
    chk("t3_count_full", count_o, 32'd4);
    chk("t3_head", 32'(rand_o), 32'hB8);
    cfg_write(1'b1, 8'hFF);
    cfg_write(1'b0, 8'h02);
    chk("t3_count_frozen", count_o, 32'd4);
    chk("t3_busy", 32'(busy_o), 32'd1);
    rand_ready_i = 1'b1;
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    repeat (6) tick();
    chk("t3_count_after", count_o, 32'd5);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    // poly write while busy ignored, seed write taken at this start
    push_exp5(8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17);
    run_words(5);
    chk("t3_count_total", count_o, 32'd10);
    chk("t3_drained2", 32'(exp_q.size()), 32'd0);

    // 4) locked config writes ignored
    setup(8'hB8, 8'h01);
    lock_i = 1'b1;
    cfg_write(1'b1, 8'hFF);
    cfg_write(1'b0, 8'h55);
    lock_i = 1'b0;
    push_exp5(8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3);
    run_words(5);
    chk("t4_count", count_o, 32'd5);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5) start+stop together, stop mid-run, reset mid-run
    setup(8'hB8, 8'h01);
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("t5_startstop_busy", 32'(busy_o), 32'd0);
    repeat (3) tick();
    chk("t5_startstop_valid", 32'(rand_valid_o), 32'd0);
    pulse_start();
    tick(); tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t5_stop_busy", 32'(busy_o), 32'd0);
    chk("t5_stop_count", count_o, 32'd2);
    tick(); tick();
    chk("t5_state_held", count_o, 32'd2);
    exp_q.push_back(8'hB8);
    exp_q.push_back(8'h5C);
    rand_ready_i = 1'b1;
    repeat (4) tick();
    chk("t5_drain_valid", 32'(rand_valid_o), 32'd0);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    rand_ready_i = 1'b0;
    pulse_start();
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_valid", 32'(rand_valid_o), 32'd0);
    chk("t5_rst_rand", 32'(rand_o), 32'd0);
    chk("t5_rst_count", count_o, 32'd0);
    rst_i = 1'b0;

    // 6) stuck-at-0xFF sequence against the health test
    setup(8'h80, 8'hFF);
    pulse_start();
    repeat (8) tick();
`ifdef PRNG_HEALTH_EN
    chk("t6_health", 32'(health_fail_o), 32'd1);
    chk("t6_flushed", 32'(rand_valid_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    pulse_start();
    tick();
    chk("t6_restart_blocked", 32'(busy_o), 32'd0);
    chk("t6_health_sticky", 32'(health_fail_o), 32'd1);
`else
    chk("t6_health", 32'(health_fail_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd1);
    chk("t6_full_count", count_o, 32'd4);
    chk("t6_head", 32'(rand_o), 32'hFF);
`endif
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
